// File: rtl/temp_packer_pkg.sv
// Shared types and constants for the multi-channel temperature packer.
// Counter widths and parameter legality helpers live here.
package temp_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    WRITE,
    WAIT
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_OUT_W       = 12;
  localparam int DEF_HI_BITS     = 2;
  localparam int DEF_ADDR_W      = 11;
  localparam int DEF_N_CH        = 2;
  localparam int DEF_FRAME_WORDS = 20;
  localparam int DEF_LO_BASE     = 16;
  localparam int DEF_TRIG_ADDR   = 479;
  localparam int DEF_WR_BASE     = 479;
  localparam int DEF_STB_CYCLES  = 4;
  localparam int DEF_WE_GAP      = 28;

  // bits needed to hold 0..n-1
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int FRAME_CW = cnt_w(DEF_FRAME_WORDS);
  localparam int STB_CW   = cnt_w(DEF_STB_CYCLES);
  localparam int BURST_CW = cnt_w(DEF_WE_GAP + DEF_N_CH + 1);

  function automatic bit params_ok(
    input int data_w,
    input int out_w,
    input int hi_bits,
    input int addr_w,
    input int n_ch,
    input int frame_words,
    input int lo_base,
    input int trig_addr,
    input int wr_base,
    input int stb_cycles
  );
    bit ok;
    ok = 1'b1;
    if (hi_bits < 1 || hi_bits > data_w) ok = 1'b0;
    if (out_w < data_w + hi_bits) ok = 1'b0;
    if (n_ch < 1 || n_ch > 8) ok = 1'b0;
    if (frame_words < lo_base + 2 * n_ch) ok = 1'b0;
    if (stb_cycles < 1) ok = 1'b0;
    if (trig_addr >= (1 << addr_w)) ok = 1'b0;
    if (wr_base + n_ch > (1 << addr_w)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/temp_packer_if.sv
// Telemetry-in / orbit-RAM-out bundle of the temperature packer.
// master drives the byte stream, slave is the packer.
interface temp_packer_if
  import temp_packer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [DATA_W-1:0] iData;
  logic [ADDR_W-1:0] iAddrRam;
  logic              strob;
  logic              SW;
  logic              test;
  logic [OUT_W-1:0]  orbWord;
  logic              WE;
  logic [ADDR_W-1:0] oWrAddr;
  logic              busy;

  modport master (
    output iData, iAddrRam, strob, SW,
    input  test, orbWord, WE, oWrAddr, busy
  );

  modport slave (
    input  iData, iAddrRam, strob, SW,
    output test, orbWord, WE, oWrAddr, busy
  );
endinterface

// File: rtl/temp_packer_mc_bit_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both stages clear on the synchronous reset.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // shift the async bit through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/temp_packer_mc.sv
// Multi-channel temperature packer: filters strobes, tracks the frame,
// assembles N_CH words and bursts them into orbit RAM on trigger.
module temp_packer_mc
  import temp_packer_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int HI_BITS     = DEF_HI_BITS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int N_CH        = DEF_N_CH,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int LO_BASE     = DEF_LO_BASE,
  parameter int TRIG_ADDR   = DEF_TRIG_ADDR,
  parameter int WR_BASE     = DEF_WR_BASE,
  parameter int STB_CYCLES  = DEF_STB_CYCLES,
  parameter int WE_GAP      = DEF_WE_GAP
) (
  input logic          clk,
  input logic          rst,
  temp_packer_if.slave bus
);

  localparam int FCW = cnt_w(FRAME_WORDS);
  localparam int SCW = cnt_w(STB_CYCLES);
  localparam int BCW = cnt_w(WE_GAP + N_CH + 1);

  if (!params_ok(DATA_W, OUT_W, HI_BITS, ADDR_W, N_CH,
                 FRAME_WORDS, LO_BASE, TRIG_ADDR, WR_BASE,
                 STB_CYCLES)) begin : g_bad_params
    $error("temp_packer_mc: illegal parameter set");
  end

  logic syncStr;
  logic syncSW;
  logic oldSW;
  logic sw_edge;

  state_t            state;
  logic [FCW-1:0]    frame_k;
  logic [SCW-1:0]    stb_cnt;
  logic [BCW-1:0]    burst;
  logic [DATA_W-1:0] lo   [N_CH];
  logic [OUT_W-1:0]  word [N_CH];

  logic              test_q;
  logic              we_q;
  logic [OUT_W-1:0]  orb_q;
  logic [ADDR_W-1:0] addr_q;

  bit_sync u_sync_str (
    .clk (clk),
    .rst (rst),
    .d   (bus.strob),
    .q   (syncStr)
  );

  bit_sync u_sync_sw (
    .clk (clk),
    .rst (rst),
    .d   (bus.SW),
    .q   (syncSW)
  );

  assign sw_edge = syncSW != oldSW;

  // framing FSM; an SW edge overrides whatever the state did this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      oldSW   <= 1'b0;
      frame_k <= '0;
      stb_cnt <= '0;
      burst   <= '0;
      test_q  <= 1'b0;
      we_q    <= 1'b0;
      orb_q   <= '0;
      addr_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        lo[c]   <= '0;
        word[c] <= '0;
      end
    end else begin
      oldSW  <= syncSW;
      test_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (syncStr) begin
            if (stb_cnt == SCW'(STB_CYCLES - 1)) begin
              stb_cnt <= '0;
              state   <= SAMPLE;
            end else begin
              stb_cnt <= stb_cnt + 1'b1;
            end
          end else begin
            stb_cnt <= '0;
          end
        end

        SAMPLE: begin
          if (!sw_edge) begin
            for (int c = 0; c < N_CH; c++) begin
              if (frame_k == FCW'(LO_BASE + 2 * c))
                lo[c] <= bus.iData;
              if (frame_k == FCW'(LO_BASE + 2 * c + 1))
                word[c] <= OUT_W'({bus.iData[HI_BITS-1:0], lo[c]});
            end
          end
          if (frame_k == FCW'(FRAME_WORDS - 1)) begin
            frame_k <= '0;
            if (bus.iAddrRam == ADDR_W'(TRIG_ADDR)) begin
              burst <= '0;
              state <= WRITE;
            end else begin
              state <= WAIT;
            end
          end else begin
            frame_k <= frame_k + 1'b1;
            state   <= WAIT;
          end
        end

        WRITE: begin
          burst <= burst + 1'b1;
          we_q  <= 1'b0;
          for (int c = 0; c < N_CH; c++) begin
            if (burst == BCW'(WE_GAP + c)) begin
              we_q   <= 1'b1;
              addr_q <= ADDR_W'(WR_BASE + c);
              orb_q  <= word[c];
            end
          end
          if (burst == BCW'(WE_GAP + N_CH)) begin
            addr_q <= '0;
            state  <= WAIT;
          end
        end

        WAIT: begin
          if (!syncStr) begin
            we_q  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (sw_edge) begin
        test_q  <= 1'b1;
        frame_k <= '0;
        burst   <= '0;
        if (state == WRITE) begin
          we_q   <= 1'b0;
          addr_q <= '0;
          state  <= WAIT;
        end
        if (state == SAMPLE)
          state <= WAIT;
      end
    end
  end

  assign bus.test    = test_q;
  assign bus.WE      = we_q;
  assign bus.orbWord = orb_q;
  assign bus.oWrAddr = addr_q;
  assign bus.busy    = state == WRITE;

endmodule
